// File: rtl/multicycle_control_unit_if.sv
// Control-unit <-> datapath bundle: opcode/memory handshake in, datapath control strobes out.
// master = control unit, slave = datapath side.
interface multicycle_control_unit_if #(
   parameter int unsigned OP_W    = 6,
   parameter int unsigned ALUOP_W = 3,
   parameter int unsigned STATE_W = 4
);
   logic [OP_W-1:0]    op;
   logic               mem_ready;
   logic               PCWrite;
   logic               PCWriteCond;
   logic               PCWriteCondNe;
   logic               IorD;
   logic               MemRead;
   logic               MemWrite;
   logic               IRWrite;
   logic               MemtoReg;
   logic               RegDst;
   logic               RegWrite;
   logic               ALUSrcA;
   logic [1:0]         ALUSrcB;
   logic [1:0]         PCSource;
   logic [ALUOP_W-1:0] ALUOp;
   logic               illegal_op;
   logic [STATE_W-1:0] state_dbg;

   modport master (
      input  op, mem_ready,
      output PCWrite, PCWriteCond, PCWriteCondNe, IorD, MemRead, MemWrite, IRWrite,
             MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, PCSource, ALUOp,
             illegal_op, state_dbg
   );

   modport slave (
      output op, mem_ready,
      input  PCWrite, PCWriteCond, PCWriteCondNe, IorD, MemRead, MemWrite, IRWrite,
             MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, PCSource, ALUOp,
             illegal_op, state_dbg
   );
endinterface

// File: rtl/multicycle_control_unit.sv
// Multi-cycle MIPS-subset control FSM: fetch/decode/execute/memory/writeback sequencing
// with a memory-ready handshake and illegal-opcode flagging.
module multicycle_control_unit #(
   parameter int unsigned OP_W     = 6,
   parameter int unsigned ALUOP_W  = 3,
   parameter int unsigned MEM_WAIT = 1,
   parameter int unsigned STATE_W  = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   multicycle_control_unit_if.master  bus
);

   localparam logic [OP_W-1:0] OP_RTYPE = OP_W'(6'b000000);
   localparam logic [OP_W-1:0] OP_LW    = OP_W'(6'b100011);
   localparam logic [OP_W-1:0] OP_SW    = OP_W'(6'b101011);
   localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(6'b000100);
   localparam logic [OP_W-1:0] OP_BNE   = OP_W'(6'b000101);
   localparam logic [OP_W-1:0] OP_J     = OP_W'(6'b000010);
   localparam logic [OP_W-1:0] OP_ADDI  = OP_W'(6'b001000);
   localparam logic [OP_W-1:0] OP_ANDI  = OP_W'(6'b001100);

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADDR  = 4'd2,
      S_MEMRD    = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWR    = 4'd5,
      S_RTYPE_EX = 4'd6,
      S_RTYPE_WB = 4'd7,
      S_BRANCH   = 4'd8,
      S_JUMP     = 4'd9,
      S_IMM_EX   = 4'd10,
      S_IMM_WB   = 4'd11
   } state_e;

   state_e          state_q, state_d;
   logic [OP_W-1:0] op_q;
   logic            mem_go;
   logic            op_legal;

   // Memory states complete on mem_ready, or unconditionally when waiting is disabled.
   assign mem_go   = (MEM_WAIT == 0) || bus.mem_ready;
   assign op_legal = (bus.op == OP_RTYPE) || (bus.op == OP_LW)   || (bus.op == OP_SW)  ||
                     (bus.op == OP_BEQ)   || (bus.op == OP_BNE)   || (bus.op == OP_J)   ||
                     (bus.op == OP_ADDI)  || (bus.op == OP_ANDI);
   assign bus.state_dbg = STATE_W'(state_q);

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_FETCH;
      else        state_q <= state_d;
   end

   // Opcode latch: later states ignore the live op
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                   op_q <= '0;
      else if (state_q == S_DECODE) op_q <= bus.op;
   end

   // Next-state logic
   always_comb begin
      state_d = S_FETCH;
      case (state_q)
         S_FETCH:    state_d = mem_go ? S_DECODE : S_FETCH;
         S_DECODE: begin
            if      (bus.op == OP_RTYPE)                     state_d = S_RTYPE_EX;
            else if ((bus.op == OP_LW) || (bus.op == OP_SW)) state_d = S_MEMADDR;
            else if ((bus.op == OP_BEQ) || (bus.op == OP_BNE)) state_d = S_BRANCH;
            else if (bus.op == OP_J)                         state_d = S_JUMP;
            else if ((bus.op == OP_ADDI) || (bus.op == OP_ANDI)) state_d = S_IMM_EX;
            else                                             state_d = S_FETCH;
         end
         S_MEMADDR:  state_d = (op_q == OP_SW) ? S_MEMWR : S_MEMRD;
         S_MEMRD:    state_d = mem_go ? S_MEMWB : S_MEMRD;
         S_MEMWB:    state_d = S_FETCH;
         S_MEMWR:    state_d = mem_go ? S_FETCH : S_MEMWR;
         S_RTYPE_EX: state_d = S_RTYPE_WB;
         S_RTYPE_WB: state_d = S_FETCH;
         S_BRANCH:   state_d = S_FETCH;
         S_JUMP:     state_d = S_FETCH;
         S_IMM_EX:   state_d = S_IMM_WB;
         S_IMM_WB:   state_d = S_FETCH;
         default:    state_d = S_FETCH;
      endcase
   end

   // Output decode; everything is forced low while reset is held
   always_comb begin
      bus.PCWrite       = 1'b0;
      bus.PCWriteCond   = 1'b0;
      bus.PCWriteCondNe = 1'b0;
      bus.IorD          = 1'b0;
      bus.MemRead       = 1'b0;
      bus.MemWrite      = 1'b0;
      bus.IRWrite       = 1'b0;
      bus.MemtoReg      = 1'b0;
      bus.RegDst        = 1'b0;
      bus.RegWrite      = 1'b0;
      bus.ALUSrcA       = 1'b0;
      bus.ALUSrcB       = 2'b00;
      bus.PCSource      = 2'b00;
      bus.ALUOp         = '0;
      bus.illegal_op    = 1'b0;
      if (rst_n) begin
         case (state_q)
            S_FETCH: begin
               bus.MemRead = 1'b1;
               bus.ALUSrcB = 2'b01;
               bus.IRWrite = mem_go;
               bus.PCWrite = mem_go;
            end
            S_DECODE: begin
               bus.ALUSrcB    = 2'b11;
               bus.illegal_op = !op_legal;
            end
            S_MEMADDR: begin
               bus.ALUSrcA = 1'b1;
               bus.ALUSrcB = 2'b10;
            end
            S_MEMRD: begin
               bus.MemRead = 1'b1;
               bus.IorD    = 1'b1;
            end
            S_MEMWB: begin
               bus.RegWrite = 1'b1;
               bus.MemtoReg = 1'b1;
            end
            S_MEMWR: begin
               bus.MemWrite = 1'b1;
               bus.IorD     = 1'b1;
            end
            S_RTYPE_EX: begin
               bus.ALUSrcA = 1'b1;
               bus.ALUOp   = ALUOP_W'(3'b010);
            end
            S_RTYPE_WB: begin
               bus.RegWrite = 1'b1;
               bus.RegDst   = 1'b1;
            end
            S_BRANCH: begin
               bus.ALUSrcA       = 1'b1;
               bus.ALUOp         = ALUOP_W'(3'b001);
               bus.PCSource      = 2'b01;
               bus.PCWriteCond   = (op_q == OP_BEQ);
               bus.PCWriteCondNe = (op_q == OP_BNE);
            end
            S_JUMP: begin
               bus.PCWrite  = 1'b1;
               bus.PCSource = 2'b10;
               bus.ALUOp    = ALUOP_W'(3'b111);
            end
            S_IMM_EX: begin
               bus.ALUSrcA = 1'b1;
               bus.ALUSrcB = 2'b10;
               bus.ALUOp   = (op_q == OP_ANDI) ? ALUOP_W'(3'b100) : ALUOP_W'(3'b011);
            end
            S_IMM_WB: bus.RegWrite = 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit: one instance with memory waits, one without.
module tb_multicycle_control_unit;

   logic clk;
   logic rst_n;
   int   total = 0;
   int   bad   = 0;

   multicycle_control_unit_if #(.OP_W(6), .ALUOP_W(3), .STATE_W(4)) ifa ();
   multicycle_control_unit_if #(.OP_W(6), .ALUOP_W(3), .STATE_W(4)) ifb ();

   multicycle_control_unit #(.OP_W(6), .ALUOP_W(3), .MEM_WAIT(1), .STATE_W(4)) u_dut (
      .clk(clk), .rst_n(rst_n), .bus(ifa)
   );
   multicycle_control_unit #(.OP_W(6), .ALUOP_W(3), .MEM_WAIT(0), .STATE_W(4)) u_dut_nw (
      .clk(clk), .rst_n(rst_n), .bus(ifb)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Field order: PCWrite PCWriteCond PCWriteCondNe IorD MemRead MemWrite IRWrite
   //              MemtoReg RegDst RegWrite ALUSrcA | ALUSrcB | PCSource | ALUOp | illegal_op
   logic [18:0] ctl_a;
   assign ctl_a = {ifa.PCWrite, ifa.PCWriteCond, ifa.PCWriteCondNe, ifa.IorD, ifa.MemRead,
                   ifa.MemWrite, ifa.IRWrite, ifa.MemtoReg, ifa.RegDst, ifa.RegWrite,
                   ifa.ALUSrcA, ifa.ALUSrcB, ifa.PCSource, ifa.ALUOp, ifa.illegal_op};

   localparam logic [18:0] E_ZERO = 19'b0_0_0_0_0_0_0_0_0_0_0_00_00_000_0;
   localparam logic [18:0] E_F1   = 19'b1_0_0_0_1_0_1_0_0_0_0_01_00_000_0;
   localparam logic [18:0] E_F0   = 19'b0_0_0_0_1_0_0_0_0_0_0_01_00_000_0;
   localparam logic [18:0] E_DEC  = 19'b0_0_0_0_0_0_0_0_0_0_0_11_00_000_0;
   localparam logic [18:0] E_ILL  = 19'b0_0_0_0_0_0_0_0_0_0_0_11_00_000_1;
   localparam logic [18:0] E_MA   = 19'b0_0_0_0_0_0_0_0_0_0_1_10_00_000_0;
   localparam logic [18:0] E_MRD  = 19'b0_0_0_1_1_0_0_0_0_0_0_00_00_000_0;
   localparam logic [18:0] E_MWB  = 19'b0_0_0_0_0_0_0_1_0_1_0_00_00_000_0;
   localparam logic [18:0] E_MWR  = 19'b0_0_0_1_0_1_0_0_0_0_0_00_00_000_0;
   localparam logic [18:0] E_RX   = 19'b0_0_0_0_0_0_0_0_0_0_1_00_00_010_0;
   localparam logic [18:0] E_RWB  = 19'b0_0_0_0_0_0_0_0_1_1_0_00_00_000_0;
   localparam logic [18:0] E_BNE  = 19'b0_0_1_0_0_0_0_0_0_0_1_00_01_001_0;
   localparam logic [18:0] E_BEQ  = 19'b0_1_0_0_0_0_0_0_0_0_1_00_01_001_0;
   localparam logic [18:0] E_J    = 19'b1_0_0_0_0_0_0_0_0_0_0_00_10_111_0;
   localparam logic [18:0] E_ANDI = 19'b0_0_0_0_0_0_0_0_0_0_1_10_00_100_0;
   localparam logic [18:0] E_ADDI = 19'b0_0_0_0_0_0_0_0_0_0_1_10_00_011_0;
   localparam logic [18:0] E_IWB  = 19'b0_0_0_0_0_0_0_0_0_1_0_00_00_000_0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // One cycle on the waiting instance: drive inputs, then sample before the next rising edge.
   task automatic step(input string tag, input logic [5:0] o, input logic rdy,
                       input int unsigned st, input logic [18:0] e);
      @(negedge clk);
      ifa.op        = o;
      ifa.mem_ready = rdy;
      #1;
      chk({tag, "/st"}, 32'(ifa.state_dbg), st);
      chk({tag, "/ctl"}, 32'(ctl_a), 32'(e));
   endtask

   task automatic release_rst();
      @(negedge clk);
      ifa.mem_ready = 1'b0;
      ifa.op        = 6'b000000;
      rst_n         = 1'b1;
   endtask

   int unsigned nw_seq [6] = '{0, 1, 2, 3, 4, 0};

   initial begin
      rst_n         = 1'b0;
      ifa.op        = 6'b000000;
      ifa.mem_ready = 1'b1;
      ifb.op        = 6'b100011;
      ifb.mem_ready = 1'b0;

      // Power-on reset: outputs low even with mem_ready high
      @(negedge clk); #1;
      chk("por/st", 32'(ifa.state_dbg), 0);
      chk("por/ctl", 32'(ctl_a), 32'(E_ZERO));
      release_rst();

      // lw with a fetch wait and three MEMRD wait cycles
      step("lw_f0",  6'b000000, 1'b0, 0, E_F0);
      step("lw_f1",  6'b000000, 1'b1, 0, E_F1);
      step("lw_dec", 6'b100011, 1'b1, 1, E_DEC);
      step("lw_ma",  6'b000000, 1'b1, 2, E_MA);
      step("lw_rd0", 6'b000000, 1'b0, 3, E_MRD);
      step("lw_rd1", 6'b000000, 1'b0, 3, E_MRD);
      step("lw_rd2", 6'b000000, 1'b0, 3, E_MRD);
      step("lw_rd3", 6'b000000, 1'b1, 3, E_MRD);
      step("lw_wb",  6'b000000, 1'b1, 4, E_MWB);

      // R-type
      step("r_f",    6'b000000, 1'b1, 0, E_F1);
      step("r_dec",  6'b000000, 1'b1, 1, E_DEC);
      step("r_ex",   6'b000000, 1'b1, 6, E_RX);
      step("r_wb",   6'b000000, 1'b1, 7, E_RWB);

      // sw
      step("sw_f",   6'b000000, 1'b1, 0, E_F1);
      step("sw_dec", 6'b101011, 1'b1, 1, E_DEC);
      step("sw_ma",  6'b000000, 1'b1, 2, E_MA);
      step("sw_wr",  6'b000000, 1'b1, 5, E_MWR);

      // bne, beq, j
      step("bne_f",  6'b000000, 1'b1, 0, E_F1);
      step("bne_dec",6'b000101, 1'b1, 1, E_DEC);
      step("bne_br", 6'b000000, 1'b1, 8, E_BNE);
      step("beq_f",  6'b000000, 1'b1, 0, E_F1);
      step("beq_dec",6'b000100, 1'b1, 1, E_DEC);
      step("beq_br", 6'b000101, 1'b1, 8, E_BEQ);
      step("j_f",    6'b000000, 1'b1, 0, E_F1);
      step("j_dec",  6'b000010, 1'b1, 1, E_DEC);
      step("j_j",    6'b000000, 1'b1, 9, E_J);

      // andi with op changed after DECODE, then addi
      step("andi_f", 6'b000000, 1'b1, 0, E_F1);
      step("andi_d", 6'b001100, 1'b1, 1, E_DEC);
      step("andi_x", 6'b000000, 1'b1, 10, E_ANDI);
      step("andi_w", 6'b000000, 1'b1, 11, E_IWB);
      step("addi_f", 6'b000000, 1'b1, 0, E_F1);
      step("addi_d", 6'b001000, 1'b1, 1, E_DEC);
      step("addi_x", 6'b001100, 1'b1, 10, E_ADDI);
      step("addi_w", 6'b000000, 1'b1, 11, E_IWB);

      // Illegal opcode: one-cycle pulse, back to FETCH
      step("ill_f",  6'b000000, 1'b1, 0, E_F1);
      step("ill_d",  6'b111111, 1'b1, 1, E_ILL);
      step("ill_f2", 6'b000000, 1'b0, 0, E_F0);

      // Reset asserted mid-MEMRD, held two cycles
      step("rs_f",   6'b000000, 1'b1, 0, E_F1);
      step("rs_dec", 6'b100011, 1'b1, 1, E_DEC);
      step("rs_ma",  6'b000000, 1'b1, 2, E_MA);
      step("rs_rd",  6'b000000, 1'b0, 3, E_MRD);
      @(negedge clk);
      rst_n         = 1'b0;
      ifa.mem_ready = 1'b1;
      #1;
      chk("rs_hold0/st", 32'(ifa.state_dbg), 0);
      chk("rs_hold0/ctl", 32'(ctl_a), 32'(E_ZERO));
      @(negedge clk); #1;
      chk("rs_hold1/st", 32'(ifa.state_dbg), 0);
      chk("rs_hold1/ctl", 32'(ctl_a), 32'(E_ZERO));
      release_rst();
      step("rs_f1",  6'b000000, 1'b1, 0, E_F1);
      step("rs_d1",  6'b000000, 1'b1, 1, E_DEC);

      // No-wait instance: advances through lw with mem_ready held low
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("nw_irw", 32'(ifb.IRWrite), 1);
      chk("nw_pcw", 32'(ifb.PCWrite), 1);
      for (int i = 0; i < 6; i++) begin
         if (i != 0) begin
            @(negedge clk); #1;
         end
         chk($sformatf("nw_st%0d", i), 32'(ifb.state_dbg), nw_seq[i]);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
